// File: rtl/shared_outff_arbiter.sv
// Round-robin arbiter sharing one registered output flop between N_REQ requesters.
// The granted requester's data bit is sampled into o each cycle of a grant of at most HOLD_CYCLES edges.
module shared_outff_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             o
);

    localparam int          IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned NR = N_REQ;

    localparam logic [IW-1:0]    PTR_RST  = IW'(N_REQ - 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [N_REQ-1:0] gnt_d;
    logic [IW-1:0]    ptr, ptr_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             o_d;

    logic             found;
    logic [IW-1:0]    winner;
    logic             rel;
    logic             load;

    // Search starts just after the last winner, so that winner is tried last.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int unsigned i = 1; i <= NR; i++) begin
            if (!found && req[(32'(ptr) + i) % NR]) begin
                found  = 1'b1;
                winner = IW'((32'(ptr) + i) % NR);
            end
        end
    end

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        ptr_d   = ptr;
        cnt_d   = cnt;
        o_d     = o;
        load    = 1'b0;
        rel     = (cnt == '0) || !req[ptr];

        case (state)
            IDLE: begin
                if (found) load = 1'b1;
            end
            GRANT: begin
                if (!rel) begin
                    cnt_d = cnt - CW'(1);
                    o_d   = din[ptr];
                end else if (found) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (load) begin
            state_d = GRANT;
            gnt_d   = ONE << winner;
            ptr_d   = winner;
            cnt_d   = CNT_LOAD;
            o_d     = din[winner];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= PTR_RST;
            cnt   <= '0;
            o     <= 1'b0;
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
            o     <= o_d;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: doc/shared_outff_arbiter.md
Name: shared_outff_arbiter

Overview:
- Round-robin arbiter that shares a single registered output flop between N_REQ requesters.
- Each requester supplies a request line and a 1-bit data input.
- The granted requester's data is sampled into the output flop every cycle of its grant; the grant lasts at most HOLD_CYCLES cycles.
- Sits in front of a single registered output pin as the only writer of that flop; used as a clocked test design for timing-constraint flows.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- HOLD_CYCLES, 2, maximum consecutive cycles per grant (>=1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- req  input  N_REQ  per-requester request, level-sensitive.
- din  input  N_REQ  per-requester data bit; din[k] belongs to requester k.
- gnt  output  N_REQ  registered one-hot grant, or all zero.
- busy  output  1  registered; equals |gnt.
- o  output  1  registered shared output flop.

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, busy=0, o=0, cnt=0, ptr=N_REQ-1. Reset while a grant is active aborts it immediately; there is no completion.
- State:
  - ptr = index of last winner.
  - cnt = remaining hold count, width max(1, clog2(HOLD_CYCLES)).
  - IDLE when gnt==0; GRANT otherwise.
- Arbitration function: search req in order ptr+1, ptr+2, ..., ptr, modulo N_REQ; the first set bit wins. The previous winner therefore has lowest priority.
- IDLE, each posedge:
  - If any req is set: gnt<=onehot(winner), ptr<=winner, cnt<=HOLD_CYCLES-1, o<=din[winner].
  - Else: stay IDLE; o holds its value.
- GRANT with index g, each posedge:
  - release = (cnt==0) or (req[g]==0).
  - No release: gnt unchanged, cnt<=cnt-1, o<=din[g].
  - Release with any req set: re-arbitrate, with no idle gap. The new winner may be g itself, but only if g is the sole requester. Load the new grant exactly as IDLE does.
  - Release with no req set: gnt<=0, busy<=0, o holds; ptr keeps g.
- Latency:
  - req high to gnt/o valid: 1 clock edge.
  - din change to o: 1 cycle while granted.
- Maximum grant length is exactly HOLD_CYCLES edges when req[g] stays high.
- HOLD_CYCLES=1 re-arbitrates every cycle.
- Requester that drops req: its grant ends at the next edge. Data sampled at that edge comes from the new winner, or o holds if there is none.
- Simultaneous requests are resolved only by the rotating priority; there is no fixed index priority after the first grant.
- gnt is always one-hot or zero; busy always equals |gnt.
- o never samples din of an ungranted requester.
- Index arithmetic wraps modulo N_REQ, including for non-power-of-two N_REQ.

Test Plan:
- Reset: gnt=0100, o=1 mid-grant, drop rst_n asynchronously mid-cycle -> gnt=0000, o=0, busy=0 before the next edge; after release, req=0001 -> gnt=0001 one edge later.
- Defaults, all req=1111 held -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001..., with busy constant 1 and no idle cycle.
- Sole requester: req=0001, din[0]=1, HOLD=2 -> gnt=0001 continuously, o=1; deassert req -> next edge gnt=0000, o stays 1.
- Early drop: req=0110, gnt=0010 at first edge; drop req[1] after one cycle -> next edge gnt=0100, o=din[2].
- HOLD_CYCLES=1, req=0101 -> gnt alternates 0001,0100,0001,...; o follows din[0], din[2] alternately.
- Data tracking: gnt=1000, toggle din[3] 0,1,1,0 -> o shows 0,1,1,0 one cycle later; toggling din[0..2] meanwhile -> o unaffected.
